// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// It drives the enables and clears of PC, IF/ID, ID/EX and EX/MEM.
// It resolves load-use hazards, taken-branch flushes, multi-cycle EX ops and
// memory-wait freezes.
// It also keeps a saturating count of the cycles in which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MULTI_LAT  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_multi_start,
  input  logic                  mem_wait,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_clear,
  output logic                  idex_clear,
  output logic                  exmem_clear,
  output logic [15:0]           stall_count
);

  localparam int CNT_W = $clog2(MULTI_LAT);
  // MULTI cycles still owed after the start cycle; the DONE cycle is the op's last EX cycle
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 2);

  typedef enum logic [1:0] {RUN, MULTI, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic             multi_stall;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Load in EX whose destination feeds a source actually read by ID; r0 never conflicts
  always_comb begin
    load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  end

  // Mealy outputs and next-state logic, in priority order reset > mem_wait > multi > branch > load-use
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_clear  = 1'b0;
    idex_clear  = 1'b0;
    exmem_clear = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    multi_stall = (state == MULTI) || ((state == RUN) && ex_multi_start);
    if (reset) begin
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = '0;
    end else if (mem_wait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else begin
      if (multi_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_clear = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_clear = 1'b1;
        idex_clear = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_clear = 1'b1;
      end
      unique case (state)
        RUN: begin
          if (ex_multi_start) begin
            if (MULTI_LAT == 2) begin
              state_nxt = DONE;
            end else begin
              state_nxt = MULTI;
              cnt_nxt   = CNT_LOAD;
            end
          end
        end
        MULTI: begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        DONE:    state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, MULTI counter and saturating stall counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_en) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: constant vector table,
// hand-written multi-cycle sequences, and random traffic against a
// behavioural model that tracks how long a multi-cycle op has sat in EX.
module tb_pipeline_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;

  localparam logic [6:0] O_RST = 7'b1111111;
  localparam logic [6:0] O_DEF = 7'b1111000;
  localparam logic [6:0] O_LU  = 7'b0011010;
  localparam logic [6:0] O_BR  = 7'b1111110;
  localparam logic [6:0] O_MUL = 7'b0001001;
  localparam logic [6:0] O_MW  = 7'b0000000;

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          br;
    logic          ms;
    logic          mw;
    logic          rst;
    logic [6:0]    exp;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
  logic          ex_branch_taken, ex_multi_start, mem_wait;
  logic          pc_en, ifid_en, idex_en, exmem_en;
  logic          ifid_clear, idex_clear, exmem_clear;
  logic [15:0]   stall_count;
  logic [6:0]    dut_out;

  int n_cmp = 0;
  int n_bad = 0;
  int m_age = 0;   // cycles the current multi-cycle op has already spent in EX
  int m_sc  = 0;   // model stall count

  always #5 clock = ~clock;

  assign dut_out = {pc_en, ifid_en, idex_en, exmem_en, ifid_clear, idex_clear, exmem_clear};

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MULTI_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_multi_start(ex_multi_start), .mem_wait(mem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_clear(ifid_clear), .idex_clear(idex_clear), .exmem_clear(exmem_clear),
    .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int rs, input int rt, input int urs, input int urt,
                              input int rd, input int rw, input int mr, input int br,
                              input int ms, input int mw, input int rst, input logic [6:0] exp);
    vec_t v;
    v.rs  = AW'(rs);  v.rt = AW'(rt);
    v.urs = urs[0];   v.urt = urt[0];
    v.rd  = AW'(rd);  v.rw = rw[0];  v.mr = mr[0];
    v.br  = br[0];    v.ms = ms[0];  v.mw = mw[0];  v.rst = rst[0];
    v.exp = exp;
    return v;
  endfunction

  // Reference behaviour for one cycle: returns the outputs and advances model state
  task automatic model_cycle(input vec_t v, output logic [6:0] o);
    bit lu;
    bit mstall;
    lu = v.mr && v.rw && (v.rd != 0) &&
         ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
    if (v.rst) begin
      o = O_RST; m_age = 0; m_sc = 0;
    end else if (v.mw) begin
      o = O_MW;
    end else begin
      mstall = (m_age > 0 && m_age < LAT - 1) || (m_age == 0 && v.ms);
      if (mstall) begin
        o = O_MUL; m_age++;
      end else begin
        if (m_age == LAT - 1) m_age = 0;
        if (v.br)      o = O_BR;
        else if (lu)   o = O_LU;
        else           o = O_DEF;
      end
    end
    if (!v.rst && !o[6]) m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
  endtask

  // One clock cycle: drive after the falling edge, compare before the rising edge
  task automatic step(input vec_t v, input bit use_tab, input bit quiet, input string name);
    logic [6:0] mo;
    int sc_before;
    @(negedge clock);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_rd = v.rd; ex_reg_write = v.rw; ex_mem_read = v.mr;
    ex_branch_taken = v.br; ex_multi_start = v.ms; mem_wait = v.mw; reset = v.rst;
    #1;
    sc_before = m_sc;
    model_cycle(v, mo);
    if (!quiet) begin
      chk({name, "_out"}, 32'(dut_out), use_tab ? 32'(v.exp) : 32'(mo));
      if (!v.rst) chk({name, "_cnt"}, 32'(stall_count), 32'(sc_before));
    end
  endtask

  vec_t tab [12];
  vec_t idle, ms1;
  int   base;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0, O_DEF);
    ms1  = mk(0,0,0,0,0,0,0,0,1,0,0, O_MUL);
    //          rs rt urs urt rd rw mr br ms mw rst
    tab[0]  = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, O_LU);   // load-use on rs
    tab[1]  = mk(3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, O_DEF);  // load has moved on
    tab[2]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, O_DEF);  // r0 never hazards
    tab[3]  = mk(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, O_DEF);  // rs not read
    tab[4]  = mk(1, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, O_LU);   // load-use on rt
    tab[5]  = mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, O_DEF);  // not a load
    tab[6]  = mk(3, 0, 1, 0, 3, 0, 1, 0, 0, 0, 0, O_DEF);  // load without write
    tab[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR);   // taken branch
    tab[8]  = mk(3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0, O_BR);   // branch beats load-use
    tab[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MW);   // memory wait
    tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_MW);   // mem_wait beats branch
    tab[11] = mk(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, O_MW);   // mem_wait beats load-use

    // Reset for two cycles, then RUN defaults with a cleared counter
    step(mk(0,0,0,0,0,0,0,0,0,0,1, O_RST), 1, 0, "reset0");
    step(mk(0,0,0,0,0,0,0,0,0,0,1, O_RST), 1, 0, "reset1");
    step(idle, 1, 0, "post_reset");
    chk("post_reset_zero", 32'(stall_count), 32'd0);

    step(tab[0], 1, 0, "lu_rs");
    step(tab[1], 1, 0, "lu_after");
    chk("lu_count_one", 32'(stall_count), 32'd1);

    for (int i = 2; i < 12; i++) step(tab[i], 1, 0, $sformatf("tab%0d", i));
    step(idle, 1, 0, "tab_end");

    // Multi-cycle op with start held high: 3 stalls, 4th cycle proceeds
    base = m_sc;
    for (int i = 0; i < LAT - 1; i++) step(ms1, 1, 0, $sformatf("multi%0d", i));
    step(mk(0,0,0,0,0,0,0,0,1,0,0, O_DEF), 1, 0, "multi_done");
    step(idle, 1, 0, "multi_after");
    chk("multi_stalls", 32'(stall_count), 32'(base + LAT - 1));

    // Memory wait mid-op freezes the op; stalls add up to 3 + 2
    base = m_sc;
    step(ms1, 1, 0, "mwm_start");
    step(mk(0,0,0,0,0,0,0,0,1,1,0, O_MW), 1, 0, "mwm_wait0");
    step(mk(0,0,0,0,0,0,0,0,1,1,0, O_MW), 1, 0, "mwm_wait1");
    step(ms1, 1, 0, "mwm_multi1");
    step(ms1, 1, 0, "mwm_multi2");
    step(mk(0,0,0,0,0,0,0,0,1,0,0, O_DEF), 1, 0, "mwm_done");
    step(idle, 1, 0, "mwm_after");
    chk("mwm_stalls", 32'(stall_count), 32'(base + 5));

    // Branch in the final cycle of the op still flushes
    step(ms1, 1, 0, "mbr_start");
    step(ms1, 1, 0, "mbr_m1");
    step(ms1, 1, 0, "mbr_m2");
    step(mk(0,0,0,0,0,0,0,1,1,0,0, O_BR), 1, 0, "mbr_done_branch");

    // Reset in the middle of an op abandons it
    step(ms1, 1, 0, "rm_start");
    step(ms1, 1, 0, "rm_multi");
    step(mk(0,0,0,0,0,0,0,0,1,0,1, O_RST), 1, 0, "rm_reset");
    step(idle, 1, 0, "rm_run");
    chk("rm_count_zero", 32'(stall_count), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v = mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             ($urandom_range(0,5) == 0), ($urandom_range(0,11) == 0), ($urandom_range(0,9) == 0),
             ($urandom_range(0,99) == 0), O_DEF);
      step(v, 0, 0, "rand");
    end

    // Saturation: long memory wait
    step(mk(0,0,0,0,0,0,0,0,0,0,1, O_RST), 1, 0, "sat_reset");
    for (int i = 0; i < 70000; i++) step(mk(0,0,0,0,0,0,0,0,0,1,0, O_MW), 1, 1, "sat");
    step(idle, 1, 0, "sat_end");
    chk("sat_ffff", 32'(stall_count), 32'h0000FFFF);
    step(mk(0,0,0,0,0,0,0,0,0,1,0, O_MW), 1, 0, "sat_more");
    step(idle, 1, 0, "sat_hold");
    chk("sat_hold_ffff", 32'(stall_count), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
